// File: rtl/dec_scoreboard.sv
// Decode-stage Tnew/Tuse hazard scoreboard: stall, forwarding-source select and MDU busy tracking.
// Optional HI/LO multiply/divide tracking is compiled in only when DEC_SCOREBOARD_HILO_EN is defined.
module dec_scoreboard #(
  parameter int AW      = 5,
  parameter int TW      = 3,
  parameter int STAGES  = 3,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          flush,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [TW-1:0] in_tuse_rs,
  input  logic [TW-1:0] in_tuse_rt,
  input  logic          in_wr,
  input  logic [AW-1:0] in_dst,
  input  logic [TW-1:0] in_tnew,
  input  logic [1:0]    in_mdu_op,
  output logic          stall,
  output logic [1:0]    fwd_rs,
  output logic [1:0]    fwd_rt,
  output logic          mdu_busy
);

  localparam int NREG   = 1 << AW;
  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  logic          pend_q [NREG];
  logic          pend_d [NREG];
  logic [TW-1:0] cnt_q  [NREG];
  logic [TW-1:0] cnt_d  [NREG];
  logic [1:0]    pos_q  [NREG];
  logic [1:0]    pos_d  [NREG];

  logic hazard_stall;
  logic mdu_stall;
  logic issue;

  always_comb begin
    hazard_stall = 1'b0;
    if (in_valid && !flush) begin
      if (in_rs != '0 && pend_q[in_rs] && cnt_q[in_rs] > in_tuse_rs) hazard_stall = 1'b1;
      if (in_rt != '0 && pend_q[in_rt] && cnt_q[in_rt] > in_tuse_rt) hazard_stall = 1'b1;
    end
  end

  // Forward only once the producer's result exists (cnt==0); pos names the stage holding it.
  assign fwd_rs = (pend_q[in_rs] && cnt_q[in_rs] == '0) ? pos_q[in_rs] : 2'd0;
  assign fwd_rt = (pend_q[in_rt] && cnt_q[in_rt] == '0) ? pos_q[in_rt] : 2'd0;
  assign stall  = hazard_stall | mdu_stall;
  assign issue  = in_valid && !flush && !stall;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      pend_d[i] = pend_q[i];
      cnt_d[i]  = cnt_q[i];
      pos_d[i]  = pos_q[i];
      if (pend_q[i]) begin
        cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - TW'(1) : '0;
        pos_d[i] = pos_q[i] + 2'd1;
        if (pos_q[i] == 2'(STAGES)) pend_d[i] = 1'b0;
      end
      // A newly issued writer replaces whatever older entry tracked the same register.
      if (issue && in_wr && in_dst != '0 && in_dst == AW'(i)) begin
        pend_d[i] = 1'b1;
        cnt_d[i]  = in_tnew;
        pos_d[i]  = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        pend_q[i] <= 1'b0;
        cnt_q[i]  <= '0;
        pos_q[i]  <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        pend_q[i] <= pend_d[i];
        cnt_q[i]  <= cnt_d[i];
        pos_q[i]  <= pos_d[i];
      end
    end
  end

`ifdef DEC_SCOREBOARD_HILO_EN
  logic [CW-1:0] mdu_cnt_q;
  logic [CW-1:0] mdu_cnt_d;

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_cnt_q != '0) mdu_cnt_d = mdu_cnt_q - CW'(1);
    if (issue && in_mdu_op == 2'b01) mdu_cnt_d = CW'(MUL_LAT);
    else if (issue && in_mdu_op == 2'b10) mdu_cnt_d = CW'(DIV_LAT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mdu_cnt_q <= '0;
    else        mdu_cnt_q <= mdu_cnt_d;
  end

  assign mdu_stall = in_valid && in_mdu_op != 2'b00 && mdu_cnt_q != '0;
  assign mdu_busy  = mdu_cnt_q != '0;
`else
  logic [CW-1:0] unused_mdu;
  assign unused_mdu = {CW{^in_mdu_op}};
  assign mdu_stall  = 1'b0;
  assign mdu_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_dec_scoreboard.sv
// Directed bench for dec_scoreboard: hazard stalls, forwarding, reset/flush and MDU busy windows.
module tb_dec_scoreboard;
  localparam int AW = 5;
  localparam int TW = 3;
`ifdef DEC_SCOREBOARD_HILO_EN
  localparam int EXP_DIV = 10;
  localparam int EXP_MUL = 5;
`else
  localparam int EXP_DIV = 0;
  localparam int EXP_MUL = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid, flush, in_wr;
  logic [AW-1:0] in_rs, in_rt, in_dst;
  logic [TW-1:0] in_tuse_rs, in_tuse_rt, in_tnew;
  logic [1:0]    in_mdu_op;
  logic          stall, mdu_busy;
  logic [1:0]    fwd_rs, fwd_rt;

  int tests_run = 0;
  int tests_failed = 0;

  dec_scoreboard #(.AW(AW), .TW(TW), .STAGES(3), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .in_rs(in_rs), .in_rt(in_rt), .in_tuse_rs(in_tuse_rs), .in_tuse_rt(in_tuse_rt),
    .in_wr(in_wr), .in_dst(in_dst), .in_tnew(in_tnew), .in_mdu_op(in_mdu_op),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    in_valid = 1'b0; flush = 1'b0; in_wr = 1'b0;
    in_rs = '0; in_rt = '0; in_dst = '0;
    in_tuse_rs = 3'd7; in_tuse_rt = 3'd7; in_tnew = '0; in_mdu_op = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_idle();
    repeat (4) step();
  endtask

  task automatic issue_wr(input logic [AW-1:0] dst, input logic [TW-1:0] tnew);
    set_idle();
    in_valid = 1'b1; in_wr = 1'b1; in_dst = dst; in_tnew = tnew;
  endtask

  task automatic test_reset();
    set_idle();
    in_valid = 1'b1; in_rs = 5'd1; in_tuse_rs = 3'd0; in_wr = 1'b1; in_dst = 5'd1; in_tnew = 3'd3;
    #2 reset = 1'b0;
    @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rst_stall: got %0b want 0", stall); end
    tests_run++; if (fwd_rs !== 2'd0) begin tests_failed++; $display("FAIL rst_fwd_rs: got %0d want 0", fwd_rs); end
    tests_run++; if (fwd_rt !== 2'd0) begin tests_failed++; $display("FAIL rst_fwd_rt: got %0d want 0", fwd_rt); end
    tests_run++; if (mdu_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0b want 0", mdu_busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rst_release_stall: got %0b want 0", stall); end
    drain();
    $display("[TB] test_reset done");
  endtask

  task automatic test_load_use();
    drain();
    issue_wr(5'd8, 3'd2);
    @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lu_issue_stall: got %0b want 0", stall); end
    step();
    set_idle(); in_valid = 1'b1; in_rs = 5'd8; in_tuse_rs = 3'd1;
    @(negedge clk);
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL lu_stall: got %0b want 1", stall); end
    step();
    @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lu_release: got %0b want 0", stall); end
    tests_run++; if (fwd_rs !== 2'd0) begin tests_failed++; $display("FAIL lu_fwd_cnt1: got %0d want 0", fwd_rs); end
    step();
    set_idle(); in_valid = 1'b1; in_rs = 5'd8; in_tuse_rs = 3'd0;
    @(negedge clk);
    tests_run++; if (fwd_rs !== 2'd3) begin tests_failed++; $display("FAIL lu_fwd_w: got %0d want 3", fwd_rs); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lu_w_stall: got %0b want 0", stall); end
    step();
    @(negedge clk);
    tests_run++; if (fwd_rs !== 2'd0) begin tests_failed++; $display("FAIL lu_retired: got %0d want 0", fwd_rs); end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_alu_fwd();
    drain();
    issue_wr(5'd9, 3'd1);
    step();
    set_idle(); in_valid = 1'b1; in_rs = 5'd9; in_tuse_rs = 3'd0;
    @(negedge clk);
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL alu_stall: got %0b want 1", stall); end
    step();
    @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL alu_release: got %0b want 0", stall); end
    tests_run++; if (fwd_rs !== 2'd2) begin tests_failed++; $display("FAIL alu_fwd: got %0d want 2", fwd_rs); end
    $display("[TB] test_alu_fwd done");
  endtask

  task automatic test_reg0();
    drain();
    issue_wr(5'd0, 3'd2);
    step();
    set_idle(); in_valid = 1'b1; in_tuse_rs = 3'd0; in_tuse_rt = 3'd0;
    @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL r0_stall: got %0b want 0", stall); end
    tests_run++; if (fwd_rs !== 2'd0) begin tests_failed++; $display("FAIL r0_fwd: got %0d want 0", fwd_rs); end
    $display("[TB] test_reg0 done");
  endtask

  task automatic test_overwrite();
    drain();
    issue_wr(5'd5, 3'd2);
    step();
    issue_wr(5'd5, 3'd0);
    @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL ow_second_issue: got %0b want 0", stall); end
    step();
    set_idle(); in_valid = 1'b1; in_rt = 5'd5; in_tuse_rt = 3'd0;
    @(negedge clk);
    tests_run++; if (fwd_rt !== 2'd1) begin tests_failed++; $display("FAIL ow_fwd_rt: got %0d want 1", fwd_rt); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL ow_stall: got %0b want 0", stall); end
    $display("[TB] test_overwrite done");
  endtask

  task automatic test_flush();
    drain();
    issue_wr(5'd6, 3'd3);
    flush = 1'b1;
    step();
    set_idle(); in_valid = 1'b1; in_rs = 5'd6; in_tuse_rs = 3'd0;
    @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL flush_stall: got %0b want 0", stall); end
    tests_run++; if (fwd_rs !== 2'd0) begin tests_failed++; $display("FAIL flush_fwd: got %0d want 0", fwd_rs); end
    $display("[TB] test_flush done");
  endtask

  task automatic test_stall_no_record();
    drain();
    issue_wr(5'd10, 3'd3);
    step();
    issue_wr(5'd11, 3'd3); in_rs = 5'd10; in_tuse_rs = 3'd0;
    @(negedge clk);
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL nr_stall: got %0b want 1", stall); end
    step();
    set_idle(); in_valid = 1'b1; in_rs = 5'd11; in_tuse_rs = 3'd0;
    @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL nr_not_recorded: got %0b want 0", stall); end
    $display("[TB] test_stall_no_record done");
  endtask

  task automatic test_reset_mid();
    drain();
    issue_wr(5'd1, 3'd3); step();
    issue_wr(5'd2, 3'd3); step();
    issue_wr(5'd3, 3'd3); step();
    set_idle(); in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd2; in_tuse_rs = 3'd0; in_tuse_rt = 3'd0;
    @(negedge clk);
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL rm_pre_stall: got %0b want 1", stall); end
    reset = 1'b0;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rm_async_stall: got %0b want 0", stall); end
    tests_run++; if (fwd_rs !== 2'd0) begin tests_failed++; $display("FAIL rm_fwd_rs: got %0d want 0", fwd_rs); end
    tests_run++; if (fwd_rt !== 2'd0) begin tests_failed++; $display("FAIL rm_fwd_rt: got %0d want 0", fwd_rt); end
    tests_run++; if (mdu_busy !== 1'b0) begin tests_failed++; $display("FAIL rm_busy: got %0b want 0", mdu_busy); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rm_release_stall: got %0b want 0", stall); end
    in_rs = 5'd1; in_rt = 5'd3;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rm_stale_stall: got %0b want 0", stall); end
    step();
    @(negedge clk);
    tests_run++; if (fwd_rt !== 2'd0) begin tests_failed++; $display("FAIL rm_stale_fwd: got %0d want 0", fwd_rt); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_mdu(input logic [1:0] op, input int exp_cycles);
    int stall_cycles;
    stall_cycles = 0;
    drain();
    set_idle(); in_valid = 1'b1; in_mdu_op = op;
    @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL mdu_start_stall op=%0d: got %0b want 0", op, stall); end
    step();
    set_idle(); in_valid = 1'b1; in_mdu_op = 2'b11;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests_run++;
      if (stall !== (i < exp_cycles)) begin
        tests_failed++; $display("FAIL mdu_stall op=%0d cyc=%0d: got %0b want %0b", op, i, stall, (i < exp_cycles));
      end
      tests_run++;
      if (mdu_busy !== (i < exp_cycles)) begin
        tests_failed++; $display("FAIL mdu_busy op=%0d cyc=%0d: got %0b want %0b", op, i, mdu_busy, (i < exp_cycles));
      end
      if (stall === 1'b1) stall_cycles++;
      step();
    end
    tests_run++;
    if (stall_cycles != exp_cycles) begin
      tests_failed++; $display("FAIL mdu_window op=%0d: got %0d cycles want %0d", op, stall_cycles, exp_cycles);
    end
    $display("[TB] test_mdu op=%0d done, %0d stall cycles", op, stall_cycles);
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_reg0();
    test_overwrite();
    test_flush();
    test_stall_no_record();
    test_reset_mid();
    test_mdu(2'b10, EXP_DIV);
    test_mdu(2'b01, EXP_MUL);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
